stream_mux_nx: RTL
==================

// Module: stream_mux_nx
// PURPOSE
//   Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every port.
//   Successor to the combinational 2-input muxes: adds depth (1-entry output register),
//   channel count (NUM_IN) and flow control.
//   Sits between datapath producers (ALU, memory read port, immediates) and a shared consumer
//   such as the register-file write port or the bus.
// PARAMETERS
//   DATA_WIDTH  16  width of each data channel in bits
//   NUM_IN      4   number of input channels, >= 2
//   SEL_WIDTH   -   localparam = clog2(NUM_IN), width of sel/out_src
// PORTS
//   clk        in   1                     system clock, rising edge
//   rst_n      in   1                     asynchronous active-low reset
//   in_data    in   NUM_IN*DATA_WIDTH     channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   in   NUM_IN                per-channel valid
//   in_ready   out  NUM_IN                per-channel ready (combinational)
//   sel        in   SEL_WIDTH             channel select (ignored when STREAM_MUX_RR_EN)
//   out_data   out  DATA_WIDTH            registered output data
//   out_valid  out  1                     output register holds data
//   out_ready  in   1                     consumer accepts out_data
//   out_src    out  SEL_WIDTH             index of the channel that supplied out_data
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, RR pointer=NUM_IN-1.
//     Hold state until the first rising clk edge after rst_n goes high.
//   - load_ok = !out_valid || out_ready. Output register accepts a word this cycle only if load_ok.
//   - Grant g:
//     - Fixed mode: g = sel, only if sel < NUM_IN.
//     - If sel >= NUM_IN: no grant, all in_ready=0, register unchanged.
//   - in_ready[i] = load_ok && (i == g). All other in_ready bits are 0.
//   - Input transfer on channel i: in_valid[i] && in_ready[i] at a clk edge.
//     - out_data <= channel i, out_src <= i, out_valid <= 1.
//   - Output transfer: out_valid && out_ready.
//     - Without a simultaneous input transfer: out_valid <= 0. out_data and out_src keep their values.
//   - Simultaneous input and output transfer in one cycle: the new word replaces the old one.
//     Sustains 1 word/cycle with no bubble.
//   - Latency: exactly 1 clk from input transfer to out_valid.
//   - out_valid && !out_ready: out_data and out_src are stable and no input is granted (backpressure).
//   - sel may change on any cycle. It is sampled only at the transfer edge.
//   - No combinational path from in_data to out_data.
//   - Reset asserted mid-transfer: the word is dropped and outputs take their reset values immediately.
// CONFIGURATION
//   STREAM_MUX_RR_EN defined:
//     - sel is ignored.
//     - g = first i with in_valid[i], searched from (ptr+1) mod NUM_IN upward with wrap-around.
//     - If no channel is valid, there is no grant.
//     - ptr <= g only on an input transfer.
//     - Fair: each of k requesting channels is served within k transfers.
//     - in_ready then depends combinationally on in_valid.
//   STREAM_MUX_RR_EN undefined:
//     - Fixed mode as above.
//     - No pointer register is built.
// STRUCTURE
//   - Shared package mux_pkg holds:
//     - clog2 function.
//     - Constants DEF_DATA_WIDTH=16 and DEF_NUM_IN=4.
//   - Sub-module rr_arbiter (NUM_IN req in, one-hot grant out, advance strobe, pointer register).
//     Instantiated only under STREAM_MUX_RR_EN.
//   - Top level contains the grant-to-index encode, the data select and the output register.
// TESTING (DATA_WIDTH=16, NUM_IN=4)
//   1. Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=16'h0000 and out_src=0
//      asynchronously, before the next edge.
//   2. Fixed select: sel=2, in_valid=4'b0100, in_data[2]=16'hBEEF, out_ready=1
//      -> next cycle out_valid=1, out_data=16'hBEEF, out_src=2.
//      in_ready=4'b0100 throughout.
//   3. Backpressure: out_valid=1 with out_ready=0 for 3 cycles while sel=1, in_valid=4'b0010
//      -> in_ready=0 for all 3 cycles, out_data held, channel 1 not consumed.
//      Raise out_ready -> channel 1 word appears 1 cycle later.
//   4. Throughput: sel=0 streaming 16'h0001..16'h0008 with out_ready=1 constantly
//      -> 8 consecutive out_valid cycles, in order, no gap.
//   5. Invalid select: sel=3 with NUM_IN=3 -> in_ready=0 and out_valid stays 0.
//   6. RR (STREAM_MUX_RR_EN): in_valid=4'b1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0.
//      Drop in_valid[1] -> sequence 0,2,3,0.

Source files
------------

// File: rtl/stream_mux_nx_pkg.sv
// rtl/stream_mux_nx_pkg.sv - shared constants and helpers for the stream mux
package mux_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_IN     = 4;

    // Minimum of 1 so single-bit selects stay legal vectors.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_mux_nx_if.sv
// rtl/stream_mux_nx_if.sv - N-input valid/ready stream bundle for stream_mux_nx
interface stream_mux_nx_if
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_IN     = DEF_NUM_IN
);
    localparam int SEL_WIDTH = clog2(NUM_IN);

    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN-1:0]            in_ready;
    logic [SEL_WIDTH-1:0]         sel;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [SEL_WIDTH-1:0]         out_src;

    // master: producers plus consumer around the mux; slave: the mux itself
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );

endinterface

// File: rtl/stream_mux_nx_rr_arbiter.sv
// rtl/stream_mux_nx_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer advances on strobe
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              adv,
    output logic [NUM_IN-1:0] gnt
);
    localparam int SEL_WIDTH = clog2(NUM_IN);

    logic [SEL_WIDTH-1:0] ptr;

    // Search starts just after the last winner, so it becomes lowest priority.
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_WIDTH'(NUM_IN - 1);
        end else if (adv) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (gnt[i]) begin
                    ptr <= SEL_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx.sv
// rtl/stream_mux_nx.sv - N-input registered stream mux; STREAM_MUX_RR_EN selects round-robin instead of sel
module stream_mux_nx
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_IN     = DEF_NUM_IN
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_nx_if.slave bus
);
    localparam int SEL_WIDTH = clog2(NUM_IN);

    logic [NUM_IN-1:0]     gnt;
    logic [SEL_WIDTH-1:0]  g_idx;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  load_ok;
    logic                  in_fire;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [SEL_WIDTH-1:0]  src_q;

    assign load_ok = !valid_q || bus.out_ready;

`ifdef STREAM_MUX_RR_EN
    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.in_valid),
        .adv   (in_fire),
        .gnt   (gnt)
    );
`else
    // An out-of-range sel matches no channel, so nothing is granted.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(bus.sel) == i) begin
                gnt[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                g_idx  = SEL_WIDTH'(i);
                g_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready = load_ok ? gnt : '0;
    assign in_fire      = |(bus.in_valid & bus.in_ready);

    // A new word overwrites a departing one in the same cycle: full rate, no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
        end else if (in_fire) begin
            data_q  <= g_data;
            valid_q <= 1'b1;
            src_q   <= g_idx;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_src   = src_q;

endmodule
